// File: rtl/exec_shift_stage_pkg.sv
// exec_shift_stage_pkg: shift-op encodings, RV32 funct3 constants and skid-buffer states
// shared by the execute-stage shift unit.
`default_nettype none

package exec_shift_stage_pkg;

  typedef enum logic [1:0] {
    SHOP_SLL = 2'd0,
    SHOP_SRL = 2'd1,
    SHOP_SRA = 2'd2,
    SHOP_ILL = 2'd3
  } shop_e;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // funct7_5 only distinguishes SRL from SRA; it is a don't-care for SLL.
  function automatic shop_e decode_shop(input logic [2:0] f3, input logic f7_5);
    shop_e op;
    op = SHOP_ILL;
    if (f3 == F3_SLL) begin
      op = SHOP_SLL;
    end else if (f3 == F3_SR) begin
      op = f7_5 ? SHOP_SRA : SHOP_SRL;
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_shift_stage_shifter.sv
// shiftX32: combinational 32-bit barrel shifter (left/right, logical/arithmetic).
// Left shifts reuse the right-shift network by bit-reversing input and output.
`default_nettype none

module shiftX32 (
  input  logic [31:0] a,
  input  logic [4:0]  n,
  input  logic        rl,
  input  logic        sign,
  output logic [31:0] y
);

  logic [31:0] w_stage [0:5];
  logic        w_fill;

  assign w_fill = sign & rl & a[31];

  genvar i;
  genvar k;

  for (i = 0; i < 32; i++) begin : g_rev_in
    assign w_stage[0][i] = rl ? a[i] : a[31-i];
  end

  for (k = 0; k < 5; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign w_stage[k+1] = n[k] ? {{SH{w_fill}}, w_stage[k][31:SH]} : w_stage[k];
  end

  for (i = 0; i < 32; i++) begin : g_rev_out
    assign y[i] = rl ? w_stage[5][i] : w_stage[5][31-i];
  end

endmodule

`default_nettype wire

// File: rtl/exec_shift_stage.sv
// exec_shift_stage: registered RV32 shift execute stage with valid/ready on both sides.
// Define EXEC_SHIFT_SKID_EN for a two-entry skid buffer with a registered in_ready.
`default_nettype none

module exec_shift_stage
  import exec_shift_stage_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  shop_e       w_shop;
  logic        w_rl;
  logic        w_sign;
  logic [31:0] w_sh_y;
  logic [31:0] w_res_new;
  logic        w_ill_new;
  logic        w_accept;
  logic        w_drain;
  logic        w_unused;

  assign w_shop    = decode_shop(funct3, funct7_5);
  assign w_rl      = (w_shop == SHOP_SRL) || (w_shop == SHOP_SRA);
  assign w_sign    = (w_shop == SHOP_SRA);
  assign w_ill_new = (w_shop == SHOP_ILL);
  assign w_res_new = w_ill_new ? 32'h0 : w_sh_y;
  assign w_unused  = ^op_b[31:5];

  shiftX32 u_shift (
    .a    (op_a),
    .n    (op_b[4:0]),
    .rl   (w_rl),
    .sign (w_sign),
    .y    (w_sh_y)
  );

  assign w_accept = in_valid && in_ready && !flush;
  assign w_drain  = out_valid && out_ready;

`ifdef EXEC_SHIFT_SKID_EN

  skid_state_e      state_q, state_d;
  logic [31:0]      main_res_q, main_res_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             main_ill_q, main_ill_d;
  logic [31:0]      skid_res_q, skid_res_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_ill_q, skid_ill_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      main_res_q <= '0;
      main_tag_q <= '0;
      main_ill_q <= 1'b0;
      skid_res_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_res_q <= main_res_d;
      main_tag_q <= main_tag_d;
      main_ill_q <= main_ill_d;
      skid_res_q <= skid_res_d;
      skid_tag_q <= skid_tag_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    main_res_d = main_res_q;
    main_tag_d = main_tag_q;
    main_ill_d = main_ill_q;
    skid_res_d = skid_res_q;
    skid_tag_d = skid_tag_q;
    skid_ill_d = skid_ill_q;
    case (state_q)
      SKID_EMPTY: begin
        if (w_accept) begin
          main_res_d = w_res_new;
          main_tag_d = rd_tag;
          main_ill_d = w_ill_new;
          state_d    = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (w_accept && w_drain) begin
          main_res_d = w_res_new;
          main_tag_d = rd_tag;
          main_ill_d = w_ill_new;
        end else if (w_accept) begin
          // Main entry is stalled; park the new op behind it.
          skid_res_d = w_res_new;
          skid_tag_d = rd_tag;
          skid_ill_d = w_ill_new;
          state_d    = SKID_TWO;
        end else if (w_drain) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (w_drain) begin
          main_res_d = skid_res_q;
          main_tag_d = skid_tag_q;
          main_ill_d = skid_ill_q;
          state_d    = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (flush) begin
      state_d = SKID_EMPTY;
    end
  end

  assign in_ready  = (state_q != SKID_TWO);
  assign out_valid = (state_q != SKID_EMPTY);
  assign result    = main_res_q;
  assign out_tag   = main_tag_q;
  assign illegal   = main_ill_q;

`else

  logic             valid_q, valid_d;
  logic [31:0]      res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ill_q, ill_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      tag_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    tag_d   = tag_q;
    ill_d   = ill_q;
    if (w_accept) begin
      valid_d = 1'b1;
      res_d   = w_res_new;
      tag_d   = rd_tag;
      ill_d   = w_ill_new;
    end else if (w_drain) begin
      valid_d = 1'b0;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign result    = res_q;
  assign out_tag   = tag_q;
  assign illegal   = ill_q;

`endif

endmodule

`default_nettype wire

// File: tb/tb_exec_shift_stage.sv
// tb_exec_shift_stage: scoreboard bench for exec_shift_stage (works with or without
// EXEC_SHIFT_SKID_EN); expected results come from an independent shift model.
`default_nettype none

module tb_exec_shift_stage;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      op_a = '0;
  logic [31:0]      op_b = '0;
  logic [2:0]       funct3 = '0;
  logic             funct7_5 = 1'b0;
  logic [TAG_W-1:0] rd_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      result;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;

  always #5 clk = ~clk;

  exec_shift_stage #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .rd_tag    (rd_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  bit   rnd_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f3, input logic f7,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [4:0] amt;
    amt   = b[4:0];
    e.tag = tag;
    e.ill = 1'b0;
    case (f3)
      3'b001:  e.res = a << amt;
      3'b101:  e.res = f7 ? 32'($signed(a) >>> amt) : (a >> amt);
      default: begin
        e.res = 32'h0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Handshakes complete at the next rising edge; inputs change only just after rising edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_result", result, e.res);
          chk("sb_tag", 32'(out_tag), 32'(e.tag));
          chk("sb_illegal", 32'(illegal), 32'(e.ill));
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back(model(op_a, op_b, funct3, funct7_5, rd_tag));
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input logic f7, input logic [TAG_W-1:0] tag);
    int n;
    n        = 0;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    funct3   = f3;
    funct7_5 = f7;
    rd_tag   = tag;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input logic f7, input logic [TAG_W-1:0] t,
                          input logic [31:0] exp_res, input logic exp_ill);
    send(a, b, f3, f7, t);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'h1);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    chk({tag, "_tag"}, 32'(out_tag), 32'(t));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_tag", 32'(out_tag), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    directed("sll31", 32'h0000_0001, 32'd31, 3'b001, 1'b0, 5'd1, 32'h8000_0000, 1'b0);
    directed("sra4", 32'h8000_0000, 32'h0000_0024, 3'b101, 1'b1, 5'd2, 32'hF800_0000, 1'b0);
    directed("srl4", 32'h8000_0000, 32'h0000_0024, 3'b101, 1'b0, 5'd3, 32'h0800_0000, 1'b0);
    directed("illegal", 32'hDEAD_BEEF, 32'h0000_0003, 3'b000, 1'b0, 5'd7, 32'h0, 1'b1);
    directed("amt0", 32'h1234_5678, 32'hFFFF_FFE0, 3'b101, 1'b1, 5'd4, 32'h1234_5678, 1'b0);
    directed("sll_f7", 32'h0F0F_0F0F, 32'd4, 3'b001, 1'b1, 5'd5, 32'hF0F0_F0F0, 1'b0);
    directed("illegal_f3_7", 32'h0000_FFFF, 32'd1, 3'b111, 1'b1, 5'd6, 32'h0, 1'b1);
    wait_drain();

    // Random ops under random writeback backpressure, checked by the scoreboard.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [2:0] f3;
          case ($urandom_range(0, 4))
            0, 1:    f3 = 3'b001;
            2, 3:    f3 = 3'b101;
            default: f3 = 3'($urandom_range(0, 7));
          endcase
          send($urandom, $urandom, f3, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_drain();

    // Backpressure: three back-to-back ops with writeback stalled.
    out_ready = 1'b0;
    fork
      begin
        send(32'h1, 32'd1, 3'b001, 1'b0, 5'd10);
        send(32'h1, 32'd2, 3'b001, 1'b0, 5'd11);
        send(32'h1, 32'd3, 3'b001, 1'b0, 5'd12);
      end
      begin
        int acc0;
        acc0 = acc_cnt;
        repeat (4) @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_result", result, 32'h2);
        chk("bp_tag", 32'(out_tag), 32'd10);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
`ifdef EXEC_SHIFT_SKID_EN
        chk("bp_accepts", 32'(acc_cnt - acc0), 32'd2);
`else
        chk("bp_accepts", 32'(acc_cnt - acc0), 32'd1);
`endif
        repeat (2) @(negedge clk);
        chk("bp_hold_result", result, 32'h2);
        chk("bp_hold_tag", 32'(out_tag), 32'd10);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with one entry held and a simultaneous accept attempt.
    out_ready = 1'b0;
    send(32'hA5A5_0000, 32'd8, 3'b101, 1'b0, 5'd13);
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    op_a      = 32'h0000_00FF;
    op_b      = 32'd4;
    funct3    = 3'b001;
    funct7_5  = 1'b0;
    rd_tag    = 5'd14;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(out_valid), 32'h0);
    repeat (4) @(negedge clk);
    chk("flush_quiet", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    send(32'hFFFF_FFF0, 32'd8, 3'b101, 1'b1, 5'd21);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_result", result, 32'h0);
    chk("arst_tag", 32'(out_tag), 32'h0);
    chk("arst_illegal", 32'(illegal), 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    directed("post_rst", 32'h8000_0001, 32'd1, 3'b101, 1'b1, 5'd9, 32'hC000_0000, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
